// File: rtl/contador_ad_bcd_param.sv
// Up/down field counter for RTC date/time setting: wrap-around range, press-and-hold
// auto-repeat from an internal clock-enable tick, clamped load, combinational BCD output.
module contador_ad_bcd_param #(
    parameter int unsigned MIN_VAL    = 1,
    parameter int unsigned MAX_VAL    = 12,
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned VW         = 7,
    parameter int unsigned SEL_CODE   = 5,
    parameter int unsigned TICK_DIV   = 13000000,
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            en_count,
    input  logic                  enUP,
    input  logic                  enDOWN,
    input  logic                  load,
    input  logic [VW-1:0]         load_val,
    output logic [VW-1:0]         value,
    output logic [4*DIGITS-1:0]   data_bcd,
    output logic                  wrap_up,
    output logic                  wrap_down
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned CW = (VW > 4) ? VW : 4;

    // Elaboration-time legality checks on the parameter set
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("contador_ad_bcd_param: DIGITS must be 1..4");
    end
    if (MAX_VAL >= 10**DIGITS) begin : g_bad_max_digits
        $error("contador_ad_bcd_param: MAX_VAL does not fit in DIGITS decimal digits");
    end
    if (MIN_VAL > MAX_VAL) begin : g_bad_range
        $error("contador_ad_bcd_param: MIN_VAL must not exceed MAX_VAL");
    end
    if (2**VW <= MAX_VAL) begin : g_bad_vw
        $error("contador_ad_bcd_param: VW too narrow for MAX_VAL");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("contador_ad_bcd_param: TICK_DIV must be >= 2");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("contador_ad_bcd_param: HOLD_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_dir_up;
    logic [TW-1:0]   r_tick;
    logic [HW-1:0]   r_hold;

    logic            w_req;
    logic            w_dir_up;
    logic            w_keep;
    logic            w_tick;
    logic [HW-1:0]   w_hold_inc;
    logic [VW-1:0]   w_up_next;
    logic [VW-1:0]   w_dn_next;
    logic            w_up_wrap;
    logic            w_dn_wrap;
    logic [VW-1:0]   w_step_val;
    logic            w_step_wu;
    logic            w_step_wd;
    logic [VW-1:0]   w_clamp;
    logic [CW-1:0]   w_rem;
    logic [4*DIGITS-1:0] w_bcd;

    // Request decode: selected field with exactly one direction pressed
    assign w_req      = (en_count == 4'(SEL_CODE)) && (enUP ^ enDOWN);
    assign w_dir_up   = enUP;
    assign w_keep     = w_req && (w_dir_up == r_dir_up);
    assign w_tick     = (r_tick == TW'(TICK_DIV - 1));
    assign w_hold_inc = r_hold + HW'(1);

    // Next value for one step in either direction, with wrap detection
    assign w_up_wrap  = (value >= VW'(MAX_VAL));
    assign w_dn_wrap  = (value <= VW'(MIN_VAL));
    assign w_up_next  = w_up_wrap ? VW'(MIN_VAL) : value + VW'(1);
    assign w_dn_next  = w_dn_wrap ? VW'(MAX_VAL) : value - VW'(1);
    assign w_step_val = w_dir_up ? w_up_next : w_dn_next;
    assign w_step_wu  = w_dir_up & w_up_wrap;
    assign w_step_wd  = ~w_dir_up & w_dn_wrap;

    // Load value saturated into the legal range
    assign w_clamp = (load_val < VW'(MIN_VAL)) ? VW'(MIN_VAL) :
                     (load_val > VW'(MAX_VAL)) ? VW'(MAX_VAL) : load_val;

    // Binary to BCD by repeated constant division; digit 0 is the units digit
    always_comb begin
        w_bcd = '0;
        w_rem = CW'(value);
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_bcd[4*i +: 4] = 4'(w_rem % CW'(10));
            w_rem           = w_rem / CW'(10);
        end
    end

    assign data_bcd = w_bcd;

    // Press/hold/repeat FSM, counter register and wrap pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_dir_up  <= 1'b0;
            r_tick    <= '0;
            r_hold    <= '0;
            value     <= VW'(MIN_VAL);
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
        end else begin
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            if (load) begin
                value   <= w_clamp;
                r_state <= S_IDLE;
                r_tick  <= '0;
                r_hold  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_req) begin
                            value     <= w_step_val;
                            wrap_up   <= w_step_wu;
                            wrap_down <= w_step_wd;
                            r_dir_up  <= w_dir_up;
                            r_tick    <= '0;
                            r_hold    <= '0;
                            r_state   <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (!w_keep) begin
                            r_state <= S_IDLE;
                        end else if (w_tick) begin
                            r_tick <= '0;
                            r_hold <= w_hold_inc;
                            if (w_hold_inc == HW'(HOLD_TICKS)) begin
                                value     <= w_step_val;
                                wrap_up   <= w_step_wu;
                                wrap_down <= w_step_wd;
                                r_state   <= S_REPEAT;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    S_REPEAT: begin
                        if (!w_keep) begin
                            r_state <= S_IDLE;
                        end else if (w_tick) begin
                            r_tick    <= '0;
                            value     <= w_step_val;
                            wrap_up   <= w_step_wu;
                            wrap_down <= w_step_wd;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_contador_ad_bcd_param.sv
// Bench for contador_ad_bcd_param: directed scenarios plus randomized press/hold/load/reset
// segments, checked every cycle against a press-age based reference model.
module tb_contador_ad_bcd_param;

    localparam int unsigned MINV = 1;
    localparam int unsigned MAXV = 12;
    localparam int unsigned DIG  = 2;
    localparam int unsigned VWB  = 7;
    localparam int unsigned SEL  = 5;
    localparam int unsigned TDIV = 4;
    localparam int unsigned HT   = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     en_count;
    logic           enUP;
    logic           enDOWN;
    logic           load;
    logic [VWB-1:0] load_val;
    logic [VWB-1:0] value;
    logic [4*DIG-1:0] data_bcd;
    logic           wrap_up;
    logic           wrap_down;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: current value, wrap pulses, and age of the current press in edges
    int m_val;
    bit m_wu;
    bit m_wd;
    bit m_act;
    bit m_dir;
    int m_n;

    always #5 clk = ~clk;

    contador_ad_bcd_param #(
        .MIN_VAL(MINV), .MAX_VAL(MAXV), .DIGITS(DIG), .VW(VWB),
        .SEL_CODE(SEL), .TICK_DIV(TDIV), .HOLD_TICKS(HT)
    ) dut (
        .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .load(load), .load_val(load_val), .value(value), .data_bcd(data_bcd),
        .wrap_up(wrap_up), .wrap_down(wrap_down)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic model_step(input bit up);
        if (up) begin
            if (m_val >= int'(MAXV)) begin m_val = int'(MINV); m_wu = 1'b1; end
            else m_val = m_val + 1;
        end else begin
            if (m_val <= int'(MINV)) begin m_val = int'(MAXV); m_wd = 1'b1; end
            else m_val = m_val - 1;
        end
    endtask

    // One clock edge of the reference: first step on press, then steps by press age
    task automatic model_edge();
        bit valid;
        bit dir;
        int lv;
        valid = (int'(en_count) == int'(SEL)) && (enUP != enDOWN);
        dir   = enUP;
        lv    = int'(load_val);
        m_wu  = 1'b0;
        m_wd  = 1'b0;
        if (!reset) begin
            m_val = int'(MINV);
            m_act = 1'b0;
        end else if (load) begin
            m_val = (lv < int'(MINV)) ? int'(MINV) : (lv > int'(MAXV)) ? int'(MAXV) : lv;
            m_act = 1'b0;
        end else if (m_act) begin
            if (!valid || dir != m_dir) begin
                m_act = 1'b0;
            end else begin
                m_n++;
                if ((m_n - 1) >= int'(HT * TDIV) && ((m_n - 1) % int'(TDIV)) == 0)
                    model_step(dir);
            end
        end else if (valid) begin
            m_act = 1'b1;
            m_dir = dir;
            m_n   = 1;
            model_step(dir);
        end
    endtask

    // Advance one clock, update the model, compare all outputs after the edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("value",     int'(value),     m_val);
        chk("wrap_up",   int'(wrap_up),   int'(m_wu));
        chk("wrap_down", int'(wrap_down), int'(m_wd));
        chk("data_bcd",  int'(data_bcd),  to_bcd(m_val));
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = VWB'(v);
        cycle();
        load     = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en_count = 4'd0; enUP = 1'b0; enDOWN = 1'b0;
        load = 1'b0; load_val = '0;
        m_val = 0; m_wu = 0; m_wd = 0; m_act = 0; m_dir = 0; m_n = 0;

        // Reset and BCD
        repeat (3) cycle();
        chk("rst_value", int'(value), 1);
        chk("rst_bcd", int'(data_bcd), 8'h01);
        reset = 1'b1;
        do_load(10);
        chk("load10_bcd", int'(data_bcd), 8'h10);

        // Single press from 11
        do_load(11);
        en_count = 4'(SEL);
        enUP = 1'b1;
        cycle();
        enUP = 1'b0;
        chk("single_press", int'(value), 12);
        repeat (6) cycle();
        chk("single_stays", int'(value), 12);

        // Wrap and hold timing from 12
        enUP = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            cycle();
            if (e == 1) begin
                chk("hold_e1", int'(value), 1);
                chk("hold_e1_wu", int'(wrap_up), 1);
            end
            if (e == 9)  chk("hold_e9",  int'(value), 2);
            if (e == 13) chk("hold_e13", int'(value), 3);
            if (e == 17) chk("hold_e17", int'(value), 4);
        end
        // Direction switch mid-repeat: one idle edge, then a decrement
        enUP = 1'b0; enDOWN = 1'b1;
        cycle();
        chk("switch_idle", int'(value), 4);
        cycle();
        chk("switch_dec", int'(value), 3);
        enDOWN = 1'b0;
        cycle();

        // Down wrap from 1
        do_load(1);
        enDOWN = 1'b1;
        cycle();
        chk("down_wrap", int'(value), 12);
        chk("down_wrap_wd", int'(wrap_down), 1);
        enDOWN = 1'b0;
        cycle();

        // Invalid requests
        do_load(6);
        en_count = 4'd4; enUP = 1'b1;
        repeat (10) cycle();
        chk("unsel", int'(value), 6);
        en_count = 4'(SEL); enDOWN = 1'b1;
        repeat (10) cycle();
        chk("both", int'(value), 6);
        enUP = 1'b0; enDOWN = 1'b0;
        cycle();

        // Load clamp and priority over a held request
        do_load(0);
        chk("clamp_lo", int'(value), 1);
        do_load(15);
        chk("clamp_hi", int'(value), 12);
        enUP = 1'b1;
        do_load(7);
        chk("load_prio", int'(value), 7);
        chk("load_no_wu", int'(wrap_up), 0);
        enUP = 1'b0;
        cycle();

        // Reset during auto-repeat, then a fresh first step
        do_load(1);
        enUP = 1'b1;
        repeat (14) cycle();
        reset = 1'b0;
        cycle();
        chk("rst_mid", int'(value), 1);
        reset = 1'b1;
        cycle();
        chk("rst_fresh", int'(value), 2);
        cycle();
        chk("rst_no_repeat", int'(value), 2);
        enUP = 1'b0;
        cycle();

        // Randomized segments of held inputs with occasional load and reset
        for (int s = 0; s < 300; s++) begin
            int p;
            int len;
            en_count = ($urandom_range(0, 99) < 85) ? 4'(SEL) : 4'($urandom_range(0, 15));
            p = int'($urandom_range(0, 3));
            enUP   = (p == 0) || (p == 2);
            enDOWN = (p == 1) || (p == 2);
            load     = ($urandom_range(0, 19) == 0);
            load_val = VWB'($urandom_range(0, 127));
            reset    = ($urandom_range(0, 39) != 0);
            len = int'($urandom_range(1, 25));
            for (int c = 0; c < len; c++) begin
                cycle();
                load  = 1'b0;
                reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
